// File: rtl/shared_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among NumCores APU masters. An in-order
// tag FIFO records which core owns each in-flight op so responses route back.
module shared_fpu_arbiter #(
    parameter int NumCores       = 8,
    parameter int NumArgs        = 3,
    parameter int OpWidth        = 6,
    parameter int TypeWidth      = 3,
    parameter int InFlagsWidth   = 15,
    parameter int OutFlagsWidth  = 5,
    parameter int MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumCores-1:0]              core_req_i,
    output logic [NumCores-1:0]              core_gnt_o,
    input  logic [NumCores*NumArgs*32-1:0]   core_operands_i,
    input  logic [NumCores*OpWidth-1:0]      core_op_i,
    input  logic [NumCores*TypeWidth-1:0]    core_type_i,
    input  logic [NumCores*InFlagsWidth-1:0] core_flags_i,
    output logic [NumCores-1:0]              core_rvalid_o,
    output logic [31:0]                      core_result_o,
    output logic [OutFlagsWidth-1:0]         core_rflags_o,
    output logic                             fpu_req_o,
    input  logic                             fpu_gnt_i,
    output logic [NumArgs*32-1:0]            fpu_operands_o,
    output logic [OpWidth-1:0]               fpu_op_o,
    output logic [TypeWidth-1:0]             fpu_type_o,
    output logic [InFlagsWidth-1:0]          fpu_flags_o,
    input  logic                             fpu_rvalid_i,
    input  logic [31:0]                      fpu_result_i,
    input  logic [OutFlagsWidth-1:0]         fpu_rflags_i,
    output logic                             busy_o,
    output logic                             err_o
);
    localparam int PW = $clog2(NumCores);
    localparam int FW = $clog2(MaxOutstanding);
    localparam int CW = FW + 1;

    logic [PW-1:0] r_rr;
    logic          r_lock;
    logic [PW-1:0] r_lock_idx;
    logic [PW-1:0] r_tags [MaxOutstanding];
    logic [FW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic [PW-1:0] w_sel;
    logic          w_full, w_acc, w_pop, w_push;

    // Rotating priority search starting at the rr pointer; a pending lock overrides it.
    always_comb begin
        logic found;
        int   j;
        w_sel = r_rr;
        found = 1'b0;
        for (int i = 0; i < NumCores; i++) begin
            j = int'(r_rr) + i;
            if (j >= NumCores) j = j - NumCores;
            if (!found && core_req_i[j]) begin
                w_sel = PW'(j);
                found = 1'b1;
            end
        end
        if (r_lock) w_sel = r_lock_idx;
    end

    // No bypass when full: a same-cycle pop does not free a slot until next cycle.
    assign w_full    = (r_cnt == CW'(MaxOutstanding));
    assign fpu_req_o = (r_lock | (|core_req_i)) & ~w_full;
    assign w_acc     = fpu_req_o & fpu_gnt_i;
    assign w_push    = w_acc;
    assign w_pop     = fpu_rvalid_i & (r_cnt != '0);

    assign core_gnt_o     = w_acc ? (NumCores'(1) << w_sel) : '0;
    assign fpu_operands_o = core_operands_i[int'(w_sel)*NumArgs*32 +: NumArgs*32];
    assign fpu_op_o       = core_op_i[int'(w_sel)*OpWidth +: OpWidth];
    assign fpu_type_o     = core_type_i[int'(w_sel)*TypeWidth +: TypeWidth];
    assign fpu_flags_o    = core_flags_i[int'(w_sel)*InFlagsWidth +: InFlagsWidth];

    assign core_rvalid_o = w_pop ? (NumCores'(1) << r_tags[r_rd]) : '0;
    assign core_result_o = w_pop ? fpu_result_i : '0;
    assign core_rflags_o = w_pop ? fpu_rflags_i : '0;
    assign busy_o        = (r_cnt != '0);
    assign err_o         = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_rr          <= (int'(w_sel) == NumCores-1) ? '0 : w_sel + PW'(1);
                r_lock        <= 1'b0;
                r_tags[r_wr]  <= w_sel;
                r_wr          <= r_wr + FW'(1);
            end else if (fpu_req_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (w_pop) r_rd <= r_rd + FW'(1);
            if (fpu_rvalid_i && r_cnt == '0) r_err <= 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_shared_fpu_arbiter.sv
// Randomized bench: model of cores, FPU and arbiter policy (queue of owner tags).
module tb_shared_fpu_arbiter;
    localparam int N = 8, NA = 3, OW = 6, TW = 3, IFW = 15, OFW = 5, MO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        core_req_i, core_gnt_o, core_rvalid_o;
    logic [N*NA*32-1:0]  core_operands_i;
    logic [N*OW-1:0]     core_op_i;
    logic [N*TW-1:0]     core_type_i;
    logic [N*IFW-1:0]    core_flags_i;
    logic [31:0]         core_result_o, fpu_result_i;
    logic [OFW-1:0]      core_rflags_o, fpu_rflags_i;
    logic                fpu_req_o, fpu_gnt_i, fpu_rvalid_i, busy_o, err_o;
    logic [NA*32-1:0]    fpu_operands_o;
    logic [OW-1:0]       fpu_op_o;
    logic [TW-1:0]       fpu_type_o;
    logic [IFW-1:0]      fpu_flags_o;

    shared_fpu_arbiter #(.NumCores(N), .NumArgs(NA), .OpWidth(OW), .TypeWidth(TW),
        .InFlagsWidth(IFW), .OutFlagsWidth(OFW), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i),
        .core_type_i(core_type_i), .core_flags_i(core_flags_i),
        .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o),
        .core_rflags_o(core_rflags_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
        .fpu_type_o(fpu_type_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_result_i(fpu_result_i),
        .fpu_rflags_i(fpu_rflags_i), .busy_o(busy_o), .err_o(err_o));

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: next-priority core, locked core (-1 = none), owners in issue order.
    int           m_rr, m_lk;
    int           m_tags[$];
    bit           m_err;
    bit           pend [N];
    logic [OW-1:0]    op_a  [N];
    logic [TW-1:0]    ty_a  [N];
    logic [IFW-1:0]   fl_a  [N];
    logic [NA*32-1:0] opd_a [N];

    initial begin
        int  ph, sel, cnt;
        bit  do_rst, quiet, any, exp_req, acc, pop;
        logic [N-1:0] e_gnt, e_rv;

        rst = 1'b1;
        core_req_i = '0; core_operands_i = '0; core_op_i = '0; core_type_i = '0;
        core_flags_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0;
        fpu_result_i = '0; fpu_rflags_i = '0;
        m_rr = 0; m_lk = -1; m_err = 1'b0;
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", fpu_req_o, 1'b0);
        chk("rst_gnt", core_gnt_o, '0);
        chk("rst_rvalid", core_rvalid_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);

        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            ph     = (cyc / 50) % 4;
            do_rst = (cyc % 200 == 199);
            quiet  = do_rst || (cyc % 200 == 0);
            rst    = do_rst;
            if (do_rst) begin
                for (int c = 0; c < N; c++) pend[c] = 1'b0;
            end else if (!quiet) begin
                for (int c = 0; c < N; c++)
                    if (!pend[c] && $urandom_range(3) == 0) begin
                        pend[c]  = 1'b1;
                        op_a[c]  = OW'($urandom);
                        ty_a[c]  = TW'($urandom);
                        fl_a[c]  = IFW'($urandom);
                        opd_a[c] = {$urandom, $urandom, $urandom};
                    end
            end
            case (ph)
                0: begin fpu_gnt_i = ($urandom_range(3) != 0);
                         fpu_rvalid_i = (m_tags.size() > 0) && $urandom_range(1); end
                1: begin fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b0; end
                2: begin fpu_gnt_i = ($urandom_range(3) == 0);
                         fpu_rvalid_i = (m_tags.size() > 0) && ($urandom_range(9) < 3); end
                default: begin fpu_gnt_i = $urandom_range(1);
                         fpu_rvalid_i = ($urandom_range(3) == 0); end
            endcase
            if (quiet) begin fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0; end
            fpu_result_i = $urandom;
            fpu_rflags_i = OFW'($urandom);
            for (int c = 0; c < N; c++) begin
                core_req_i[c]                 = pend[c];
                core_op_i[c*OW +: OW]         = op_a[c];
                core_type_i[c*TW +: TW]       = ty_a[c];
                core_flags_i[c*IFW +: IFW]    = fl_a[c];
                core_operands_i[c*NA*32 +: NA*32] = opd_a[c];
            end
            #1;

            cnt = m_tags.size();
            any = 1'b0;
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && pend[(m_rr + k) % N]) sel = (m_rr + k) % N;
            any = (sel >= 0);
            if (m_lk >= 0) sel = m_lk;
            exp_req = ((m_lk >= 0) || any) && (cnt < MO);
            acc     = exp_req && fpu_gnt_i;
            pop     = fpu_rvalid_i && (cnt > 0);
            e_gnt = '0; if (acc) e_gnt[sel] = 1'b1;
            e_rv  = '0; if (pop) e_rv[m_tags[0]] = 1'b1;

            chk("fpu_req", fpu_req_o, exp_req);
            chk("core_gnt", core_gnt_o, e_gnt);
            chk("core_rvalid", core_rvalid_o, e_rv);
            chk("busy", busy_o, cnt != 0);
            chk("err", err_o, m_err);
            if (exp_req) begin
                chk("fpu_op", fpu_op_o, op_a[sel]);
                chk("fpu_type", fpu_type_o, ty_a[sel]);
                chk("fpu_flags", fpu_flags_o, fl_a[sel]);
                chk("fpu_operands", fpu_operands_o, opd_a[sel]);
            end
            if (pop) begin
                chk("result", core_result_o, fpu_result_i);
                chk("rflags", core_rflags_o, fpu_rflags_i);
            end

            if (do_rst) begin
                m_rr = 0; m_lk = -1; m_err = 1'b0;
                m_tags.delete();
            end else begin
                if (pop) void'(m_tags.pop_front());
                if (fpu_rvalid_i && cnt == 0) m_err = 1'b1;
                if (acc) begin
                    m_tags.push_back(sel);
                    m_rr = (sel + 1) % N;
                    m_lk = -1;
                    pend[sel] = 1'b0;
                end else if (exp_req) begin
                    m_lk = sel;
                end
            end
        end
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
